dm_cache_ctrl: RTL and testbench

Direct-mapped cache controller that sits directly upstream of valid_mem. It receives CPU load/store requests, drives valid_mem's write and index inputs, and consumes its valid_out together with an internal tag array to decide hit or miss. Reads use a read-allocate multi-word line refill from main memory. Writes are write-through and no-write-allocate.

---
 rtl/dm_cache_ctrl_if.sv | 49 ++++
 rtl/dm_cache_ctrl.sv | 156 +++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_cache_ctrl_if.sv
// Bus bundle for dm_cache_ctrl.
//   cpu_req_*  : CPU load/store request (valid/ready handshake)
//   cpu_resp_* : one-cycle completion pulse with load data
//   vm_*       : valid_mem set port and its combinational read-back
//   mem_req_*  : main-memory word request (valid/ready handshake)
//   mem_resp_* : main-memory read data
// modport slave is the controller; modport master is its environment
// (CPU, valid_mem and main memory).
interface dm_cache_ctrl_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_LENGTH = 6
);
  logic                    cpu_req_valid;
  logic                    cpu_req_write;
  logic [ADDR_WIDTH-1:0]   cpu_req_addr;
  logic [DATA_WIDTH-1:0]   cpu_req_wdata;
  logic                    cpu_req_ready;
  logic                    cpu_resp_valid;
  logic [DATA_WIDTH-1:0]   cpu_resp_rdata;
  logic                    vm_write;
  logic [INDEX_LENGTH-1:0] vm_index;
  logic                    vm_valid_in;
  logic                    mem_req_valid;
  logic                    mem_req_write;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic [DATA_WIDTH-1:0]   mem_req_wdata;
  logic                    mem_req_ready;
  logic                    mem_resp_valid;
  logic [DATA_WIDTH-1:0]   mem_resp_rdata;

  modport slave (
    input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    output vm_write, vm_index,
    input  vm_valid_in,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport master (
    output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    input  vm_write, vm_index,
    output vm_valid_in,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache controller in front of valid_mem.
// Loads: read-allocate, whole-line refill one word request at a time.
// Stores: write-through, no-write-allocate (resident word updated on hit).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : dm_cache_ctrl_if.slave (CPU, valid_mem and main-memory sides)
// Line validity lives only in valid_mem; tag/data arrays are never reset.
module dm_cache_ctrl #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int INDEX_LENGTH  = 6,
  parameter int OFFSET_LENGTH = 2,
  parameter int TAG_LENGTH    = ADDR_WIDTH - INDEX_LENGTH - OFFSET_LENGTH - 2
) (
  input logic         clk,
  input logic         reset,
  dm_cache_ctrl_if.slave bus
);
  localparam int NUM_CACHE_LINES = 2**INDEX_LENGTH;
  localparam int WORDS_PER_LINE  = 2**OFFSET_LENGTH;
  localparam int WA_W            = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, REFILL_DONE, WRITE_MEM, RESPOND
  } state_t;

  state_t state;

  // Latched request; byte offset is dropped, only the word address is kept.
  logic                     lat_write;
  logic [WA_W-1:0]          lat_waddr;
  logic [DATA_WIDTH-1:0]    lat_wdata;
  logic [OFFSET_LENGTH-1:0] cnt;
  logic [OFFSET_LENGTH-1:0] cnt_inc;

  logic                     rdy_q, resp_q, mreq_q, mwr_q, vmw_q;
  logic [ADDR_WIDTH-1:0]    maddr_q;
  logic [DATA_WIDTH-1:0]    mwdata_q, rdata_q;

  logic [TAG_LENGTH-1:0]    tag_array  [NUM_CACHE_LINES];
  logic [DATA_WIDTH-1:0]    data_array [NUM_CACHE_LINES][WORDS_PER_LINE];

  logic [TAG_LENGTH-1:0]    lat_tag;
  logic [INDEX_LENGTH-1:0]  lat_idx;
  logic [OFFSET_LENGTH-1:0] lat_word;
  logic                     hit;

  assign lat_tag  = lat_waddr[WA_W-1 -: TAG_LENGTH];
  assign lat_idx  = lat_waddr[INDEX_LENGTH+OFFSET_LENGTH-1 : OFFSET_LENGTH];
  assign lat_word = lat_waddr[OFFSET_LENGTH-1:0];
  assign cnt_inc  = cnt + 1'b1;
  assign hit      = bus.vm_valid_in && (tag_array[lat_idx] == lat_tag);

  // Handshake/strobe outputs are forced low combinationally while reset is
  // high so nothing leaks out in the cycle reset is first seen.
  assign bus.cpu_req_ready  = rdy_q  & ~reset;
  assign bus.cpu_resp_valid = resp_q & ~reset;
  assign bus.mem_req_valid  = mreq_q & ~reset;
  assign bus.vm_write       = vmw_q  & ~reset;
  assign bus.cpu_resp_rdata = rdata_q;
  assign bus.mem_req_write  = mwr_q;
  assign bus.mem_req_addr   = maddr_q;
  assign bus.mem_req_wdata  = mwdata_q;
  assign bus.vm_index       = lat_idx;

  // Storage arrays: no reset, written from refill data or a store hit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == REFILL_WAIT && bus.mem_resp_valid)
        data_array[lat_idx][cnt] <= bus.mem_resp_rdata;
      else if (state == LOOKUP && lat_write && hit)
        data_array[lat_idx][lat_word] <= lat_wdata;
      if (state == REFILL_DONE)
        tag_array[lat_idx] <= lat_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      rdy_q     <= 1'b1;
      resp_q    <= 1'b0;
      mreq_q    <= 1'b0;
      mwr_q     <= 1'b0;
      vmw_q     <= 1'b0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      lat_write <= 1'b0;
      lat_waddr <= '0;
      lat_wdata <= '0;
    end else begin
      resp_q <= 1'b0;
      vmw_q  <= 1'b0;
      case (state)
        IDLE: if (bus.cpu_req_valid) begin
          lat_write <= bus.cpu_req_write;
          lat_waddr <= bus.cpu_req_addr[ADDR_WIDTH-1:2];
          lat_wdata <= bus.cpu_req_wdata;
          rdy_q     <= 1'b0;
          state     <= LOOKUP;
        end
        LOOKUP: begin
          if (lat_write) begin
            rdata_q  <= '0;
            mreq_q   <= 1'b1;
            mwr_q    <= 1'b1;
            maddr_q  <= {lat_waddr, 2'b00};
            mwdata_q <= lat_wdata;
            state    <= WRITE_MEM;
          end else if (hit) begin
            rdata_q <= data_array[lat_idx][lat_word];
            resp_q  <= 1'b1;
            state   <= RESPOND;
          end else begin
            cnt     <= '0;
            mreq_q  <= 1'b1;
            mwr_q   <= 1'b0;
            maddr_q <= {lat_tag, lat_idx, {OFFSET_LENGTH{1'b0}}, 2'b00};
            state   <= REFILL_REQ;
          end
        end
        REFILL_REQ: if (bus.mem_req_ready) begin
          mreq_q <= 1'b0;
          state  <= REFILL_WAIT;
        end
        REFILL_WAIT: if (bus.mem_resp_valid) begin
          cnt <= cnt_inc;
          if (&cnt) begin
            vmw_q <= 1'b1;
            state <= REFILL_DONE;
          end else begin
            mreq_q  <= 1'b1;
            maddr_q <= {lat_tag, lat_idx, cnt_inc, 2'b00};
            state   <= REFILL_REQ;
          end
        end
        // Tag lands this edge and valid_mem sets on the same edge, so the
        // repeated LOOKUP is guaranteed to hit.
        REFILL_DONE: state <= LOOKUP;
        WRITE_MEM: if (bus.mem_req_ready) begin
          mreq_q <= 1'b0;
          resp_q <= 1'b1;
          state  <= RESPOND;
        end
        RESPOND: begin
          rdy_q <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: valid_mem stub, stalling main-memory responder,
// and a line-level cache/memory reference model.
module tb_dm_cache_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_cache_ctrl_if bus ();
  dm_cache_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; } req_t;

  int n_checks = 0, n_fail = 0;

  // valid_mem stub
  logic [63:0] vbits;
  always @(posedge clk)
    if (reset) vbits <= '0;
    else if (bus.vm_write) vbits[bus.vm_index] <= 1'b1;
  assign bus.vm_valid_in = vbits[bus.vm_index];

  // Memory contents: env_mem is what the responder serves, ref_mem is the model.
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Reference cache: index = a[9:4], tag = a[31:10].
  bit          ref_v [64];
  logic [21:0] ref_t [64];
  function automatic bit ref_hit(input logic [31:0] a);
    return ref_v[a[9:4]] && (ref_t[a[9:4]] == a[31:10]);
  endfunction
  task automatic ref_clear();
    for (int i = 0; i < 64; i++) ref_v[i] = 0;
  endtask

  // Memory responder and monitors
  int          stall = 0, resp_gap = 0, wait_cnt = 0, pdelay = 0;
  int          unstable = 0, rsp_count = 0, vm_pulses = 0;
  bit          tracking = 0, pend = 0;
  logic        first_wr, last_wr;
  logic [31:0] first_addr, first_wd, pdata;
  logic [5:0]  last_vm_idx;
  req_t        log_q [$];

  always @(negedge clk) begin
    if (reset) begin
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
      pend = 0; wait_cnt = 0; tracking = 0;
    end else begin
      bus.mem_resp_valid = 1'b0;
      if (bus.mem_req_ready) begin
        bus.mem_req_ready = 1'b0; wait_cnt = 0; tracking = 0;
        if (!last_wr) begin pend = 1; pdelay = resp_gap; end
      end else if (pend) begin
        if (pdelay == 0) begin
          bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = pdata; pend = 0; rsp_count++;
        end else pdelay--;
      end else if (bus.mem_req_valid) begin
        if (!tracking) begin
          tracking = 1; first_addr = bus.mem_req_addr; first_wd = bus.mem_req_wdata;
          first_wr = bus.mem_req_write;
        end else if ({first_wr, first_addr, first_wd} !==
                     {bus.mem_req_write, bus.mem_req_addr, bus.mem_req_wdata}) unstable++;
        if (wait_cnt >= stall) begin
          bus.mem_req_ready = 1'b1; last_wr = bus.mem_req_write;
          log_q.push_back('{bus.mem_req_write, bus.mem_req_addr, bus.mem_req_wdata});
          if (bus.mem_req_write) env_mem[bus.mem_req_addr] = bus.mem_req_wdata;
          else pdata = env_rd(bus.mem_req_addr);
        end else wait_cnt++;
      end
    end
  end

  always @(negedge clk)
    if (bus.vm_write) begin vm_pulses++; last_vm_idx = bus.vm_index; end

  // One CPU transaction; returns data, cycles from drive to response, and the
  // resp/ready levels one cycle after the response.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat,
                        output logic resp_after, output logic rdy_after);
    int g = 0;
    log_q.delete(); vm_pulses = 0; unstable = 0;
    while (!bus.cpu_req_ready && g < 100) begin @(negedge clk); g++; end
    bus.cpu_req_valid = 1'b1; bus.cpu_req_write = wr;
    bus.cpu_req_addr = a; bus.cpu_req_wdata = wd;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    lat = 1;
    while (!bus.cpu_resp_valid && lat < 2000) begin @(negedge clk); lat++; end
    rd = bus.cpu_resp_rdata;
    n_checks++;
    if (bus.cpu_resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL access_timeout addr=%h got_resp=%b want=1", a, bus.cpu_resp_valid);
    end
    @(negedge clk);
    resp_after = bus.cpu_resp_valid; rdy_after = bus.cpu_req_ready;
  endtask

  logic [31:0] rd;
  int          lat;
  logic        ra, ry;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.cpu_req_ready, bus.cpu_resp_valid, bus.mem_req_valid, bus.vm_write} !== 4'b0) begin
      n_fail++; $display("FAIL reset_outputs got=%b want=0000",
        {bus.cpu_req_ready, bus.cpu_resp_valid, bus.mem_req_valid, bus.vm_write});
    end
    reset = 1'b0; ref_clear();
    @(negedge clk);
    n_checks++;
    if (bus.cpu_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", bus.cpu_req_ready); end
    n_checks++;
    if (bus.cpu_resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h want=0", bus.cpu_resp_rdata); end
  endtask

  task automatic test_refill_stall();
    stall = 5; resp_gap = 0;
    access(1'b0, 32'h40, 32'h0, rd, lat, ra, ry);
    n_checks++;
    if (log_q.size() != 4) begin n_fail++; $display("FAIL t1_nreq got=%0d want=4", log_q.size()); end
    for (int i = 0; i < log_q.size(); i++) begin
      n_checks++;
      if ({log_q[i].wr, log_q[i].addr} !== {1'b0, 32'h40 + 32'(4*i)}) begin
        n_fail++; $display("FAIL t1_req%0d got=%b/%h want=0/%h", i, log_q[i].wr, log_q[i].addr, 32'h40 + 32'(4*i));
      end
    end
    n_checks++;
    if (unstable != 0) begin n_fail++; $display("FAIL t1_addr_stable got=%0d changes want=0", unstable); end
    n_checks++;
    if (vm_pulses != 1 || last_vm_idx !== 6'd4) begin
      n_fail++; $display("FAIL t1_vm got=%0d pulses idx %0d want=1 idx 4", vm_pulses, last_vm_idx);
    end
    n_checks++;
    if (rd !== ref_rd(32'h40)) begin n_fail++; $display("FAIL t1_rdata got=%h want=%h", rd, ref_rd(32'h40)); end
    ref_v[4] = 1; ref_t[4] = 22'h0;
    stall = 0;
  endtask

  task automatic test_hit_latency();
    access(1'b0, 32'h44, 32'h0, rd, lat, ra, ry);
    n_checks++;
    if (log_q.size() != 0) begin n_fail++; $display("FAIL t2_nreq got=%0d want=0", log_q.size()); end
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL t2_latency got=%0d want=2", lat); end
    n_checks++;
    if ({ra, ry} !== 2'b01) begin n_fail++; $display("FAIL t2_pulse_ready got=%b want=01", {ra, ry}); end
    n_checks++;
    if (rd !== ref_rd(32'h44)) begin n_fail++; $display("FAIL t2_rdata got=%h want=%h", rd, ref_rd(32'h44)); end
  endtask

  task automatic test_conflict();
    access(1'b0, 32'h440, 32'h0, rd, lat, ra, ry);
    n_checks++;
    if (log_q.size() != 4 || log_q[0].addr !== 32'h440 || log_q[3].addr !== 32'h44C) begin
      n_fail++; $display("FAIL t3_refill got=%0d reqs first=%h want=4 reqs first=440", log_q.size(),
        (log_q.size() > 0) ? log_q[0].addr : 32'hx);
    end
    n_checks++;
    if (rd !== ref_rd(32'h440)) begin n_fail++; $display("FAIL t3_rdata got=%h want=%h", rd, ref_rd(32'h440)); end
    access(1'b0, 32'h40, 32'h0, rd, lat, ra, ry);
    n_checks++;
    if (log_q.size() != 4 || vm_pulses != 1) begin
      n_fail++; $display("FAIL t3_remiss got=%0d reqs %0d vm want=4 reqs 1 vm", log_q.size(), vm_pulses);
    end
    n_checks++;
    if (rd !== ref_rd(32'h40)) begin n_fail++; $display("FAIL t3_rdata2 got=%h want=%h", rd, ref_rd(32'h40)); end
  endtask

  task automatic test_write_hit();
    access(1'b1, 32'h48, 32'hDEADBEEF, rd, lat, ra, ry);
    ref_mem[32'h48] = 32'hDEADBEEF;
    n_checks++;
    if (log_q.size() != 1 || {log_q[0].wr, log_q[0].addr, log_q[0].wdata} !== {1'b1, 32'h48, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL t4_memwrite got=%0d reqs want=1 write 48/DEADBEEF", log_q.size());
    end
    n_checks++;
    if (vm_pulses != 0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL t4_vm_rdata got=%0d/%h want=0/0", vm_pulses, rd);
    end
    access(1'b0, 32'h48, 32'h0, rd, lat, ra, ry);
    n_checks++;
    if (log_q.size() != 0 || rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL t4_readback got=%0d reqs %h want=0 reqs DEADBEEF", log_q.size(), rd);
    end
  endtask

  task automatic test_write_miss();
    access(1'b1, 32'h1000, 32'h0BADF00D, rd, lat, ra, ry);
    ref_mem[32'h1000] = 32'h0BADF00D;
    n_checks++;
    if (log_q.size() != 1 || log_q[0].wr !== 1'b1 || vm_pulses != 0) begin
      n_fail++; $display("FAIL t5_store got=%0d reqs %0d vm want=1 write 0 vm", log_q.size(), vm_pulses);
    end
    access(1'b0, 32'h1000, 32'h0, rd, lat, ra, ry);
    n_checks++;
    if (log_q.size() != 4 || log_q[0].addr !== 32'h1000) begin
      n_fail++; $display("FAIL t5_refill got=%0d reqs want=4 from 1000", log_q.size());
    end
    n_checks++;
    if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL t5_rdata got=%h want=0BADF00D", rd); end
    ref_v[0] = 1; ref_t[0] = 22'h4;
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic        wr;
      logic [31:0] a, aw, wd, exp;
      bit          h;
      wr = ($urandom_range(0, 2) == 0);
      a  = 32'($urandom_range(0, 2)) * 32'h400 + 32'($urandom_range(0, 3)) * 16 +
           32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
      aw = {a[31:2], 2'b00};
      wd = $urandom;
      stall = $urandom_range(0, 3); resp_gap = $urandom_range(0, 2);
      h = ref_hit(aw); exp = ref_rd(aw);
      access(wr, a, wd, rd, lat, ra, ry);
      if (wr) begin
        ref_mem[aw] = wd;
        n_checks++;
        if (log_q.size() != 1 || {log_q[0].wr, log_q[0].addr, log_q[0].wdata} !== {1'b1, aw, wd}) begin
          n_fail++; $display("FAIL rnd_store op%0d got=%0d reqs want=1 write %h/%h", n, log_q.size(), aw, wd);
        end
        n_checks++;
        if (vm_pulses != 0 || rd !== 32'h0) begin
          n_fail++; $display("FAIL rnd_store_side op%0d got=%0d vm %h want=0 vm 0", n, vm_pulses, rd);
        end
      end else begin
        n_checks++;
        if (rd !== exp) begin n_fail++; $display("FAIL rnd_load op%0d addr=%h got=%h want=%h", n, a, rd, exp); end
        n_checks++;
        if (log_q.size() != (h ? 0 : 4) || vm_pulses != (h ? 0 : 1)) begin
          n_fail++; $display("FAIL rnd_traffic op%0d addr=%h got=%0d reqs %0d vm want=%0d reqs %0d vm",
            n, a, log_q.size(), vm_pulses, h ? 0 : 4, h ? 0 : 1);
        end
        if (!h) begin
          for (int i = 0; i < log_q.size(); i++) begin
            n_checks++;
            if ({log_q[i].wr, log_q[i].addr} !== {1'b0, {aw[31:4], 4'h0} + 32'(4*i)}) begin
              n_fail++; $display("FAIL rnd_refill op%0d req%0d got=%h want=%h", n, i, log_q[i].addr,
                {aw[31:4], 4'h0} + 32'(4*i));
            end
          end
          ref_v[aw[9:4]] = 1; ref_t[aw[9:4]] = aw[31:10];
        end
      end
    end
    stall = 0; resp_gap = 0;
  endtask

  task automatic test_reset_mid_refill();
    int g = 0;
    stall = 0; resp_gap = 4;
    log_q.delete(); vm_pulses = 0; rsp_count = 0;
    while (!bus.cpu_req_ready && g < 100) begin @(negedge clk); g++; end
    bus.cpu_req_valid = 1'b1; bus.cpu_req_write = 1'b0; bus.cpu_req_addr = 32'h880;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    g = 0;
    while (log_q.size() < 3 && g < 200) begin @(negedge clk); g++; end
    @(negedge clk);
    n_checks++;
    if (rsp_count != 2) begin n_fail++; $display("FAIL t6_words_before got=%0d want=2", rsp_count); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.mem_req_valid, bus.cpu_req_ready, bus.vm_write} !== 3'b000) begin
      n_fail++; $display("FAIL t6_in_reset got=%b want=000", {bus.mem_req_valid, bus.cpu_req_ready, bus.vm_write});
    end
    @(negedge clk);
    reset = 1'b0; ref_clear(); resp_gap = 0;
    @(negedge clk);
    n_checks++;
    if (vm_pulses != 0) begin n_fail++; $display("FAIL t6_no_vm got=%0d want=0", vm_pulses); end
    access(1'b0, 32'h880, 32'h0, rd, lat, ra, ry);
    n_checks++;
    if (log_q.size() != 4 || log_q[0].addr !== 32'h880 || vm_pulses != 1) begin
      n_fail++; $display("FAIL t6_full_refill got=%0d reqs %0d vm want=4 reqs from 880, 1 vm", log_q.size(), vm_pulses);
    end
    n_checks++;
    if (rd !== ref_rd(32'h880)) begin n_fail++; $display("FAIL t6_rdata got=%h want=%h", rd, ref_rd(32'h880)); end
  endtask

  initial begin
    reset = 1'b1;
    bus.cpu_req_valid = 1'b0; bus.cpu_req_write = 1'b0;
    bus.cpu_req_addr = '0; bus.cpu_req_wdata = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
    test_reset();
    test_refill_stall();
    test_hit_latency();
    test_conflict();
    test_write_hit();
    test_write_miss();
    test_random();
    test_reset_mid_refill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1);
  end
endmodule
